// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types, forwarding encodings and the producer-match helper.
package pipe_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [31:0] NOP = 32'h00000013;
  // rd is stored at a fixed maximum width so the struct can live here; REGW must not exceed it
  localparam int RD_MAX = 8;
  typedef struct packed {
    logic valid;
    logic [RD_MAX-1:0] rd;
    logic we;
    logic is_load;
  } stage_t;
  function automatic logic prod_hit(stage_t s, logic [RD_MAX-1:0] r);
    return s.valid && s.we && (s.rd != '0) && (s.rd == r);
  endfunction
endpackage

// File: rtl/src_match.sv
// src_match: compares one ID source operand against the EX, MEM and WB tracked producers.
module src_match
  import pipe_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic            id_valid,
  input  logic            use_rs,
  input  logic [REGW-1:0] rs,
  input  stage_t          ex_s,
  input  stage_t          mem_s,
  input  stage_t          wb_s,
  output logic            hit_ex,
  output logic            hit_mem,
  output logic            hit_wb,
  output logic            ex_is_load
);
  logic req;
  logic [RD_MAX-1:0] r;
  assign req = id_valid && use_rs && (rs != '0);
  assign r = RD_MAX'(rs);
  assign hit_ex = req && prod_hit(ex_s, r);
  assign hit_mem = req && prod_hit(mem_s, r);
  assign hit_wb = req && prod_hit(wb_s, r);
  assign ex_is_load = ex_s.is_load;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding controller that tracks EX/MEM/WB destinations internally.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REGW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            ex_busy,
  input  logic            ex_redirect,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            flush_ifid,
  output logic            idex_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] lu_cnt
);
  stage_t ex_q, mem_q, wb_q, id_s;
  logic a_ex, a_mem, a_wb, a_ld, b_ex, b_mem, b_wb, b_ld;
  logic lu, dep, redirect, stall, squash;
  logic [1:0] sel_a, sel_b;
  src_match #(.REGW(REGW)) u_a (
    .id_valid(id_valid), .use_rs(id_use_rs1), .rs(id_rs1),
    .ex_s(ex_q), .mem_s(mem_q), .wb_s(wb_q),
    .hit_ex(a_ex), .hit_mem(a_mem), .hit_wb(a_wb), .ex_is_load(a_ld)
  );
  src_match #(.REGW(REGW)) u_b (
    .id_valid(id_valid), .use_rs(id_use_rs2), .rs(id_rs2),
    .ex_s(ex_q), .mem_s(mem_q), .wb_s(wb_q),
    .hit_ex(b_ex), .hit_mem(b_mem), .hit_wb(b_wb), .ex_is_load(b_ld)
  );
  always_comb begin
    id_s = '{valid: id_valid, rd: RD_MAX'(id_rd), we: id_we, is_load: id_is_load};
    lu = (a_ex && a_ld) || (b_ex && b_ld);
    dep = a_ex || a_mem || (a_wb && !WB_BYPASS) || b_ex || b_mem || (b_wb && !WB_BYPASS);
    redirect = ex_redirect && !ex_busy;
    stall = !ex_busy && !redirect && (FWD_EN ? lu : dep);
    squash = redirect || stall;
    pc_write = !ex_busy && !stall;
    ifid_write = !ex_busy && !stall;
    flush_ifid = redirect;
    idex_bubble = squash;
    sel_a = a_ex ? FWD_EXMEM : a_mem ? FWD_WB : FWD_RF;
    sel_b = b_ex ? FWD_EXMEM : b_mem ? FWD_WB : FWD_RF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (ex_busy) begin
      mem_q <= '0;
      wb_q <= mem_q;
    end else begin
      ex_q <= squash ? '0 : id_s;
      mem_q <= ex_q;
      wb_q <= mem_q;
      fwd_a <= (squash || !FWD_EN) ? FWD_RF : sel_a;
      fwd_b <= (squash || !FWD_EN) ? FWD_RF : sel_b;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      lu_cnt <= '0;
    end else begin
      if (!pc_write && !(&stall_cnt)) stall_cnt <= stall_cnt + CNTW'(1);
      if (stall && lu && !(&lu_cnt)) lu_cnt <= lu_cnt + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl in default, stall-only and narrow-counter builds.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_we = 1'b0, id_is_load = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic ex_busy = 1'b0, ex_redirect = 1'b0;
  logic pw0, iw0, fl0, bb0, pw1, iw1, fl1, bb1, pw2, iw2, fl2, bb2;
  logic [1:0] fa0, fb0, fa1, fb1, fa2, fb2;
  logic [15:0] sc0, lc0, sc1, lc1;
  logic [1:0] sc2, lc2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .pc_write(pw0), .ifid_write(iw0), .flush_ifid(fl0), .idex_bubble(bb0),
    .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .lu_cnt(lc0)
  );
  hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b1)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .pc_write(pw1), .ifid_write(iw1), .flush_ifid(fl1), .idex_bubble(bb1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .lu_cnt(lc1)
  );
  hazard_ctrl #(.CNTW(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .pc_write(pw2), .ifid_write(iw2), .flush_ifid(fl2), .idex_bubble(bb2),
    .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .lu_cnt(lc2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_we = we; id_is_load = ld;
    #1;
  endtask
  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask
  initial begin
    #3;
    check("rst_pc_write", pw0, 1);
    check("rst_ifid_write", iw0, 1);
    check("rst_flush", fl0, 0);
    check("rst_bubble", bb0, 0);
    check("rst_fwd", {fa0, fb0}, 0);
    check("rst_cnt", {sc0, lc0}, 0);
    tick();
    rst = 1'b0;
    // add x5,x1,x2 ; sub x6,x5,x3 ; or x7,x5,x0
    drive(1, 1, 2, 1, 1, 5, 1, 0);
    check("add_pc_write", pw0, 1);
    tick();
    drive(1, 5, 3, 1, 1, 6, 1, 0);
    check("sub_no_stall", pw0, 1);
    check("sub_no_bubble", bb0, 0);
    tick();
    check("sub_fwd_a", fa0, 2'b10);
    check("sub_fwd_b", fb0, 2'b00);
    drive(1, 5, 0, 1, 1, 7, 1, 0);
    check("or_no_stall", pw0, 1);
    tick();
    check("or_fwd_a", fa0, 2'b01);
    check("or_fwd_b", fb0, 2'b00);
    drain();
    // lw x5,0(x1) ; add x6,x5,x5
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 5, 5, 1, 1, 6, 1, 0);
    check("lu_pc_write", pw0, 0);
    check("lu_ifid_write", iw0, 0);
    check("lu_bubble", bb0, 1);
    check("lu_flush", fl0, 0);
    tick();
    check("lu_after_pc_write", pw0, 1);
    check("lu_after_bubble", bb0, 0);
    check("lu_cnt", lc0, 1);
    check("lu_stall_cnt", sc0, 1);
    tick();
    check("lu_fwd_a", fa0, 2'b01);
    check("lu_fwd_b", fb0, 2'b01);
    drain();
    // producers writing x0 never create a hazard
    drive(1, 1, 0, 1, 0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 1, 1, 6, 1, 0);
    check("x0_pc_write", pw0, 1);
    check("x0_nf_pc_write", pw1, 1);
    tick();
    check("x0_fwd", {fa0, fb0}, 0);
    drive(1, 0, 0, 1, 1, 0, 1, 0);
    check("x0_nf_pc_write2", pw1, 1);
    tick();
    check("x0_fwd2", {fa0, fb0}, 0);
    check("x0_nf_fwd", {fa1, fb1}, 0);
    drain();
    // stall-only build: add x5 then use x5 waits out EX and MEM
    pulse_rst();
    drive(1, 1, 2, 1, 1, 5, 1, 0);
    tick();
    drive(1, 5, 0, 1, 0, 6, 1, 0);
    check("nf_stall1", pw1, 0);
    check("nf_bubble1", bb1, 1);
    tick();
    check("nf_stall2", pw1, 0);
    check("nf_fwd_during", {fa1, fb1}, 0);
    tick();
    check("nf_release", pw1, 1);
    check("nf_stall_cnt", sc1, 2);
    check("nf_lu_cnt", lc1, 0);
    tick();
    check("nf_fwd_after", {fa1, fb1}, 0);
    drain();
    // busy dominates redirect; redirect after busy flushes once
    pulse_rst();
    ex_busy = 1'b1;
    ex_redirect = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("busy_flush", fl0, 0);
      check("busy_pc_write", pw0, 0);
      tick();
    end
    check("busy_stall_cnt", sc0, 4);
    check("sat_stall_cnt", sc2, 3);
    ex_busy = 1'b0;
    ex_redirect = 1'b0;
    tick();
    ex_redirect = 1'b1;
    #1;
    check("redir_flush", fl0, 1);
    check("redir_bubble", bb0, 1);
    check("redir_pc_write", pw0, 1);
    tick();
    ex_redirect = 1'b0;
    #1;
    check("redir_done_flush", fl0, 0);
    check("redir_done_bubble", bb0, 0);
    check("sat_hold", sc2, 3);
    drain();
    // reset landing in the middle of a load-use stall
    drive(1, 1, 2, 1, 1, 7, 1, 0);
    tick();
    drive(1, 7, 0, 1, 0, 8, 1, 0);
    tick();
    check("mid_pre_fwd", fa0, 2'b10);
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 5, 5, 1, 1, 6, 1, 0);
    check("mid_stall", pw0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_pc_write", pw0, 1);
    check("mid_rst_bubble", bb0, 0);
    check("mid_rst_fwd", {fa0, fb0}, 0);
    check("mid_rst_cnt", {sc0, lc0}, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_no_hazard", pw0, 1);
    check("post_rst_no_bubble", bb0, 0);
    tick();
    check("post_rst_fwd", {fa0, fb0}, 0);
    check("post_rst_stall_cnt", sc0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
